// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared encodings for the two-requester round-robin mux arbiter.
package mux2_rr_arbiter_pkg;

  localparam int DEFAULT_DATA_W    = 8;
  localparam int DEFAULT_MAX_BURST = 4;

  // Arbiter states; the numeric values are part of the block's contract.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  // Identity of the requester served most recently (round-robin pointer).
  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  // One-hot grant encodings presented on the grant port.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_A    = 2'b01;
  localparam logic [1:0] GRANT_B    = 2'b10;

endpackage

// File: rtl/mux2_rr_arbiter_fsm.sv
// Ownership FSM: tracks the current owner, burst length and round-robin
// pointer, and produces the mux select, grant and per-requester readies.
module mux2_arb_fsm
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_a,
  input  logic       valid_b,
  input  logic       out_ready,
  output logic       ready_a,
  output logic       ready_b,
  output logic       out_valid,
  output logic       sel,
  output logic [1:0] grant
);

  // Counter value at which an accepted beat closes the burst.
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  arb_state_e state_q, state_d;
  owner_e     last_q, last_d;
  logic       sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic       beat_a, beat_b;

  assign beat_a = valid_a & out_ready;
  assign beat_b = valid_b & out_ready;
  assign sel    = sel_q;

  // State, select, burst counter and pointer registers with synchronous reset;
  // the pointer starts at B so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      cnt_q   <= 8'd0;
      last_q  <= OWNER_B;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state and handshake decode: only the owner sees out_ready, and a
  // release hands straight to the other requester when it is already waiting.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    ready_a   = 1'b0;
    ready_b   = 1'b0;
    out_valid = 1'b0;
    grant     = GRANT_NONE;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (valid_a && (!valid_b || last_q == OWNER_B)) begin
          state_d = OWN_A;
          sel_d   = 1'b0;
        end else if (valid_b) begin
          state_d = OWN_B;
          sel_d   = 1'b1;
        end
      end
      OWN_A: begin
        out_valid = valid_a;
        ready_a   = out_ready;
        grant     = GRANT_A;
        if (beat_a) begin
          cnt_d = cnt_q + 8'd1;
        end
        if ((beat_a && cnt_q == LAST_BEAT) || !valid_a) begin
          last_d = OWNER_A;
          cnt_d  = 8'd0;
          if (valid_b) begin
            state_d = OWN_B;
            sel_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OWN_B: begin
        out_valid = valid_b;
        ready_b   = out_ready;
        grant     = GRANT_B;
        if (beat_b) begin
          cnt_d = cnt_q + 8'd1;
        end
        if ((beat_b && cnt_q == LAST_BEAT) || !valid_b) begin
          last_d = OWNER_B;
          cnt_d  = 8'd0;
          if (valid_a) begin
            state_d = OWN_A;
            sel_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/mux_2to1.sv
// Single-bit 2:1 multiplexer cell: y follows a when sel=0, b when sel=1.
module mux_2to1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one bitwise 2:1 mux datapath between two
// streaming requesters, with bursts bounded to MAX_BURST beats per grant.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              ready_a,
  input  logic              valid_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              ready_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel,
  output logic [1:0]        grant
);

  mux2_arb_fsm #(
    .MAX_BURST(MAX_BURST)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .valid_a  (valid_a),
    .valid_b  (valid_b),
    .out_ready(out_ready),
    .ready_a  (ready_a),
    .ready_b  (ready_b),
    .out_valid(out_valid),
    .sel      (sel),
    .grant    (grant)
  );

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    mux_2to1 u_mux (
      .a  (data_a[i]),
      .b  (data_b[i]),
      .sel(sel),
      .y  (out_data[i])
    );
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: each beat handed to a requester is
// also queued as an expected output, and output beats are popped in order.
module tb_mux2_rr_arbiter;

  typedef struct {
    logic       src;
    logic [7:0] data;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_a, valid_b;
  logic [7:0] data_a, data_b;
  logic       ready_a, ready_b;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       sel;
  logic [1:0] grant;

  logic       en_a, en_b;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  beat_t      exp_q[$];
  int         total = 0;
  int         bad   = 0;

  mux2_rr_arbiter #(
    .DATA_W   (8),
    .MAX_BURST(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_a  (valid_a),
    .data_a   (data_a),
    .ready_a  (ready_a),
    .valid_b  (valid_b),
    .data_b   (data_b),
    .ready_b  (ready_b),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .sel      (sel),
    .grant    (grant)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Hand one beat to a requester and record where it must appear on the output.
  task automatic applyStimulus(input logic src, input logic [7:0] d);
    beat_t e;
    e.src  = src;
    e.data = d;
    if (src) q_b.push_back(d);
    else     q_a.push_back(d);
    exp_q.push_back(e);
  endtask

  task automatic driveInputs();
    valid_a = en_a && (q_a.size() > 0);
    data_a  = (q_a.size() > 0) ? q_a[0] : 8'h00;
    valid_b = en_b && (q_b.size() > 0);
    data_b  = (q_b.size() > 0) ? q_b[0] : 8'h00;
  endtask

  // Observe one cycle at the falling edge, then advance producers past the
  // rising edge according to the handshakes seen in that cycle.
  task automatic stepCycle(input string tag, input logic chk, input logic [1:0] exp_grant);
    logic  fire_a, fire_b;
    beat_t e;
    @(negedge clk);
    if (chk) checkOutput({tag, "_grant"}, 32'(grant), 32'(exp_grant));
    fire_a = valid_a && ready_a;
    fire_b = valid_b && ready_b;
    if (out_valid && out_ready) begin
      checkOutput({tag, "_beat_pending"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput({tag, "_data"}, 32'(out_data), 32'(e.data));
        checkOutput({tag, "_sel"}, 32'(sel), 32'(e.src));
        checkOutput({tag, "_owner"}, 32'(grant), e.src ? 32'h2 : 32'h1);
      end
    end
    @(posedge clk);
    #1;
    if (fire_a) void'(q_a.pop_front());
    if (fire_b) void'(q_b.pop_front());
    driveInputs();
  endtask

  // Guard against a hung run.
  initial begin
    repeat (3000) @(posedge clk);
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    en_a      = 1'b1;
    en_b      = 1'b1;
    out_ready = 1'b1;

    // Reset held for two cycles with both requesters valid.
    applyStimulus(1'b0, 8'hA0);
    applyStimulus(1'b1, 8'hB0);
    driveInputs();
    repeat (2) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("rst_grant", 32'(grant), 32'h0);
      checkOutput("rst_sel", 32'(sel), 32'h0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_ready_a", 32'(ready_a), 32'h0);
      checkOutput("rst_ready_b", 32'(ready_b), 32'h0);
    end
    rst = 1'b0;
    stepCycle("rst_first", 1'b1, 2'b01);
    stepCycle("rst_arel", 1'b1, 2'b01);
    stepCycle("rst_b", 1'b1, 2'b10);
    stepCycle("rst_brel", 1'b1, 2'b10);
    stepCycle("rst_end", 1'b1, 2'b00);

    // Single requester, three back-to-back beats.
    applyStimulus(1'b0, 8'h11);
    applyStimulus(1'b0, 8'h22);
    applyStimulus(1'b0, 8'h33);
    driveInputs();
    stepCycle("single_idle", 1'b1, 2'b00);
    stepCycle("single_1", 1'b1, 2'b01);
    stepCycle("single_2", 1'b1, 2'b01);
    stepCycle("single_3", 1'b1, 2'b01);
    checkOutput("single_done", 32'(exp_q.size()), 32'd0);
    stepCycle("single_rel", 1'b1, 2'b01);
    stepCycle("single_end", 1'b1, 2'b00);

    // Continuous contention; A was served last, so B opens.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h80 + i));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'(8'h40 + i));
    for (int i = 4; i < 8; i++) applyStimulus(1'b1, 8'(8'h80 + i));
    for (int i = 4; i < 8; i++) applyStimulus(1'b0, 8'(8'h40 + i));
    driveInputs();
    stepCycle("cont_idle", 1'b1, 2'b00);
    for (int i = 0; i < 16; i++) begin
      stepCycle("cont", 1'b1, ((i / 4) % 2 == 0) ? 2'b10 : 2'b01);
    end
    checkOutput("cont_done", 32'(exp_q.size()), 32'd0);
    stepCycle("cont_end", 1'b1, 2'b00);

    // Back-pressure mid-burst; the burst must still close after four beats.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'(8'hC0 + i));
    driveInputs();
    stepCycle("bp_idle", 1'b1, 2'b00);
    stepCycle("bp_1", 1'b1, 2'b01);
    stepCycle("bp_2", 1'b1, 2'b01);
    out_ready = 1'b0;
    repeat (3) stepCycle("bp_stall", 1'b1, 2'b01);
    checkOutput("bp_held", 32'(exp_q.size()), 32'd3);
    checkOutput("bp_data_held", 32'(out_data), 32'hC2);
    checkOutput("bp_ready_low", 32'(ready_a), 32'h0);
    out_ready = 1'b1;
    stepCycle("bp_3", 1'b1, 2'b01);
    stepCycle("bp_4", 1'b1, 2'b01);
    stepCycle("bp_gap", 1'b1, 2'b00);
    stepCycle("bp_5", 1'b1, 2'b01);
    stepCycle("bp_rel", 1'b1, 2'b01);
    stepCycle("bp_end", 1'b1, 2'b00);

    // Early release: A drops valid after two beats while B waits.
    en_b = 1'b0;
    applyStimulus(1'b0, 8'hD0);
    applyStimulus(1'b0, 8'hD1);
    applyStimulus(1'b1, 8'hE0);
    applyStimulus(1'b1, 8'hE1);
    driveInputs();
    stepCycle("er_idle", 1'b1, 2'b00);
    stepCycle("er_1", 1'b1, 2'b01);
    en_b = 1'b1;
    driveInputs();
    stepCycle("er_2", 1'b1, 2'b01);
    stepCycle("er_rel", 1'b1, 2'b01);
    checkOutput("er_sel", 32'(sel), 32'h1);
    stepCycle("er_b1", 1'b1, 2'b10);
    stepCycle("er_b2", 1'b1, 2'b10);
    stepCycle("er_brel", 1'b1, 2'b10);
    stepCycle("er_end", 1'b1, 2'b00);

    // Reset after A's second beat; only B valid afterwards, A re-presents later.
    applyStimulus(1'b0, 8'hF0);
    applyStimulus(1'b0, 8'hF1);
    driveInputs();
    stepCycle("mr_idle", 1'b1, 2'b00);
    stepCycle("mr_1", 1'b1, 2'b01);
    stepCycle("mr_2", 1'b1, 2'b01);
    rst  = 1'b1;
    en_a = 1'b0;
    applyStimulus(1'b1, 8'h9E);
    applyStimulus(1'b0, 8'hF2);
    driveInputs();
    stepCycle("mr_rst", 1'b0, 2'b00);
    rst = 1'b0;
    checkOutput("mr_grant", 32'(grant), 32'h0);
    checkOutput("mr_sel", 32'(sel), 32'h0);
    checkOutput("mr_out_valid", 32'(out_valid), 32'h0);
    stepCycle("mr_idle2", 1'b1, 2'b00);
    stepCycle("mr_b", 1'b1, 2'b10);
    en_a = 1'b1;
    driveInputs();
    stepCycle("mr_brel", 1'b1, 2'b10);
    stepCycle("mr_a", 1'b1, 2'b01);
    stepCycle("mr_arel", 1'b1, 2'b01);
    stepCycle("mr_end", 1'b1, 2'b00);

    checkOutput("final_empty", 32'(exp_q.size() + q_a.size() + q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
